ram_arb_1024x16: RTL

- Two-requester arbiter sharing one 1024x16 RAM_16K_BLK instance (10-bit address, 16-bit data, 2 byte write enables, unregistered read output).
- Sits between two client engines and the RAM.
- Drives the RAM write and read ports from the winning requester and returns read data to that requester.
- Round-robin arbitration, with an optional lock for multi-cycle bursts and a bounded lock length.

---
 rtl/ram_arb_1024x16_if.sv | 42 ++++
 rtl/ram_arb_1024x16.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_arb_1024x16_if.sv
// Bus bundle between the two client engines, the arbiter and the RAM_16K_BLK ports.
// master: client/RAM side, slave: arbiter side.
interface ram_arb_1024x16_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WEN_W  = 2
);
    logic              r0_req, r0_lock, r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wd;
    logic [WEN_W-1:0]  r0_wen;
    logic              r0_gnt, r0_rvalid;
    logic [DATA_W-1:0] r0_rd;

    logic              r1_req, r1_lock, r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wd;
    logic [WEN_W-1:0]  r1_wen;
    logic              r1_gnt, r1_rvalid;
    logic [DATA_W-1:0] r1_rd;

    logic [ADDR_W-1:0] WA, RA;
    logic [DATA_W-1:0] WD, RD;
    logic [WEN_W-1:0]  WEN;
    logic              WClk_En, RClk_En;

    modport master (
        output r0_req, r0_lock, r0_we, r0_addr, r0_wd, r0_wen,
        output r1_req, r1_lock, r1_we, r1_addr, r1_wd, r1_wen,
        output RD,
        input  r0_gnt, r0_rd, r0_rvalid, r1_gnt, r1_rd, r1_rvalid,
        input  WA, RA, WD, WEN, WClk_En, RClk_En
    );

    modport slave (
        input  r0_req, r0_lock, r0_we, r0_addr, r0_wd, r0_wen,
        input  r1_req, r1_lock, r1_we, r1_addr, r1_wd, r1_wen,
        input  RD,
        output r0_gnt, r0_rd, r0_rvalid, r1_gnt, r1_rd, r1_rvalid,
        output WA, RA, WD, WEN, WClk_En, RClk_En
    );
endinterface

// File: rtl/ram_arb_1024x16.sv
// Two-requester round-robin arbiter with bounded lock tenures in front of one 1024x16 RAM.
// Define RAM_ARB_FIXED_PRIO_EN to make requester 0 always win free contention.
module ram_arb_1024x16 #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WEN_W    = 2,
    parameter int unsigned LOCK_MAX = 16
) (
    input logic               Clk,
    input logic               Rst,
    ram_arb_1024x16_if.slave  bus
);
    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W:0]  LOCK_LIM = (CNT_W+1)'(LOCK_MAX);
    localparam logic [1:0]      IDLE     = 2'd0;
    localparam logic [1:0]      OWN0     = 2'd1;
    localparam logic [1:0]      OWN1     = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic              rr_q, rr_d;
`endif
    logic              held0_c, held1_c, pick1_c, gnt0_c, gnt1_c, acc_c;
    logic              sel_we_c, sel_lock_c, wclk_c, rclk_c;
    logic [ADDR_W-1:0] sel_addr_c, wa_q, wa_d, ra_q, ra_d;
    logic [DATA_W-1:0] sel_wd_c, wd_q, wd_d;
    logic [WEN_W-1:0]  sel_wen_c, wen_c;
    logic [CNT_W:0]    tenure_c;
    logic              rv0_q, rv1_q;
    logic [DATA_W-1:0] rd0_q, rd1_q;

    // Grant selection, RAM port steering and lock/pointer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        pick1_c = 1'b0;
        held0_c = (state_q == OWN0) && bus.r0_req;
        held1_c = (state_q == OWN1) && bus.r1_req;
        // An owner that drops req loses the lock and free arbitration applies this cycle
        if (held0_c)                          pick1_c = 1'b0;
        else if (held1_c)                     pick1_c = 1'b1;
        else if (bus.r0_req && bus.r1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            pick1_c = 1'b0;
`else
            pick1_c = rr_q;
`endif
        end
        else                                  pick1_c = bus.r1_req;

        gnt0_c     = !Rst && bus.r0_req && !pick1_c;
        gnt1_c     = !Rst && bus.r1_req &&  pick1_c;
        acc_c      = gnt0_c || gnt1_c;
        sel_we_c   = pick1_c ? bus.r1_we   : bus.r0_we;
        sel_lock_c = pick1_c ? bus.r1_lock : bus.r0_lock;
        sel_addr_c = pick1_c ? bus.r1_addr : bus.r0_addr;
        sel_wd_c   = pick1_c ? bus.r1_wd   : bus.r0_wd;
        sel_wen_c  = pick1_c ? bus.r1_wen  : bus.r0_wen;

        wclk_c = acc_c && sel_we_c;
        rclk_c = acc_c && !sel_we_c;
        wen_c  = wclk_c ? sel_wen_c  : WEN_W'(0);
        wa_d   = wclk_c ? sel_addr_c : wa_q;
        wd_d   = wclk_c ? sel_wd_c   : wd_q;
        ra_d   = rclk_c ? sel_addr_c : ra_q;

        // Transfers in the current tenure including this one; the LOCK_MAX-th ends it
        tenure_c = (held0_c || held1_c) ? ({1'b0, cnt_q} + (CNT_W+1)'(1)) : (CNT_W+1)'(1);

        if (acc_c) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_d = !pick1_c;
`endif
            if (sel_lock_c && (tenure_c < LOCK_LIM)) begin
                state_d = pick1_c ? OWN1 : OWN0;
                cnt_d   = tenure_c[CNT_W-1:0];
            end else begin
                state_d = IDLE;
                cnt_d   = CNT_W'(0);
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = CNT_W'(0);
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_d    = (state_q == OWN0);
`endif
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_W'(0);
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Held RAM addresses/data and per-requester read return registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wa_q  <= ADDR_W'(0);
            ra_q  <= ADDR_W'(0);
            wd_q  <= DATA_W'(0);
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            rd0_q <= DATA_W'(0);
            rd1_q <= DATA_W'(0);
        end else begin
            wa_q  <= wa_d;
            ra_q  <= ra_d;
            wd_q  <= wd_d;
            rv0_q <= rclk_c && !pick1_c;
            rv1_q <= rclk_c &&  pick1_c;
            rd0_q <= rv0_q ? bus.RD : rd0_q;
            rd1_q <= rv1_q ? bus.RD : rd1_q;
        end
    end

    // RD is live the cycle after RClk_En, so it bypasses the holding register while rvalid is high
    assign bus.r0_gnt    = gnt0_c;
    assign bus.r1_gnt    = gnt1_c;
    assign bus.r0_rvalid = rv0_q;
    assign bus.r1_rvalid = rv1_q;
    assign bus.r0_rd     = rv0_q ? bus.RD : rd0_q;
    assign bus.r1_rd     = rv1_q ? bus.RD : rd1_q;
    assign bus.WA        = wa_d;
    assign bus.RA        = ra_d;
    assign bus.WD        = wd_d;
    assign bus.WEN       = wen_c;
    assign bus.WClk_En   = wclk_c;
    assign bus.RClk_En   = rclk_c;
endmodule
